// File: rtl/bank_select_decoder_pkg.sv
// Shared SDRAM bank-addressing defaults and the bank address type.
package bank_select_decoder_pkg;

  localparam int BS_W_DEF      = 2;
  localparam int NUM_BANKS_DEF = 4;

  typedef logic [BS_W_DEF-1:0] bank_addr_t;

endpackage

// File: rtl/bank_select_decoder_if.sv
// Command-path signals between the controller and the bank-select decoder.
interface bank_select_decoder_if
  import bank_select_decoder_pkg::*;
#(
  parameter int BS_W      = BS_W_DEF,
  parameter int NUM_BANKS = NUM_BANKS_DEF
);
  logic                 CS;
  logic [BS_W-1:0]      BSIn;
  logic [NUM_BANKS-1:0] BSOut;

  modport master (output CS, output BSIn, input BSOut);
  modport slave  (input CS, input BSIn, output BSOut);
endinterface

// File: rtl/bank_select_decoder.sv
// One-hot SDRAM bank select qualified by active-low chip select, with an
// optional registered output stage.
module bank_select_decoder
  import bank_select_decoder_pkg::*;
#(
  parameter int BS_W         = BS_W_DEF,
  parameter int NUM_BANKS    = NUM_BANKS_DEF,
  parameter bit REGISTER_OUT = 1'b0
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  bank_select_decoder_if.slave bus
);

  // Unknown chip select or address falls through to all-zero: no bank may
  // see a command on a floating select.
  function automatic logic [NUM_BANKS-1:0] bank_onehot(
    input logic [BS_W-1:0] ba,
    input logic            cs_n
  );
    logic [NUM_BANKS-1:0] oh;
    oh = '0;
    case (cs_n)
      1'b0: begin
        for (int i = 0; i < NUM_BANKS; i++)
          if (ba == BS_W'(i)) oh[i] = 1'b1;
      end
      default: oh = '0;
    endcase
    return oh;
  endfunction

  logic [NUM_BANKS-1:0] dec;
  assign dec = bank_onehot(bus.BSIn, bus.CS);

  if (REGISTER_OUT) begin : g_reg
    logic [NUM_BANKS-1:0] bs_q;

    always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) bs_q <= '0;
      else         bs_q <= dec;
    end

    assign bus.BSOut = bs_q;

    a_onehot: assert property (@(posedge Clk) $onehot0(bus.BSOut));
    a_cs_off: assert property (@(posedge Clk) disable iff (!ResetN)
                               (bus.CS === 1'b1) |=> (bus.BSOut == '0));
    a_rst:    assert property (@(posedge Clk) !ResetN |-> (bus.BSOut == '0));
  end else begin : g_comb
    logic [NUM_BANKS-1:0] bs_c;

    // Reset gates the output with no clock involvement.
    always_comb begin
      bs_c = '0;
      case (ResetN)
        1'b1:    bs_c = dec;
        default: bs_c = '0;
      endcase
    end

    assign bus.BSOut = bs_c;

    a_onehot: assert property (@(posedge Clk) $onehot0(bus.BSOut));
    a_cs_off: assert property (@(posedge Clk)
                               (bus.CS === 1'b1) |-> (bus.BSOut == '0));
    a_rst:    assert property (@(posedge Clk) !ResetN |-> (bus.BSOut == '0));
  end

endmodule

// File: tb/tb_bank_select_decoder.sv
// Directed and random checks of the bank-select decoder in comb, registered
// and three-bank configurations.
module tb_bank_select_decoder;
  import bank_select_decoder_pkg::*;

  logic Clk;
  logic ResetN;
  int   checks;
  int   failures;

  bank_select_decoder_if #(.BS_W(2), .NUM_BANKS(4)) ifc ();
  bank_select_decoder_if #(.BS_W(2), .NUM_BANKS(4)) ifr ();
  bank_select_decoder_if #(.BS_W(2), .NUM_BANKS(3)) if3 ();

  bank_select_decoder #(.BS_W(2), .NUM_BANKS(4), .REGISTER_OUT(1'b0)) u_comb (
    .Clk(Clk), .ResetN(ResetN), .bus(ifc));
  bank_select_decoder #(.BS_W(2), .NUM_BANKS(4), .REGISTER_OUT(1'b1)) u_reg (
    .Clk(Clk), .ResetN(ResetN), .bus(ifr));
  bank_select_decoder #(.BS_W(2), .NUM_BANKS(3), .REGISTER_OUT(1'b0)) u_nb3 (
    .Clk(Clk), .ResetN(ResetN), .bus(if3));

  initial begin
    Clk = 1'b0;
    forever #10 Clk = ~Clk;
  end

  function automatic logic [3:0] ref_dec(input logic cs, input bank_addr_t ba, input int nb);
    logic [3:0] one;
    one = 4'b0001;
    if (cs !== 1'b0 || $isunknown(ba) || int'(ba) >= nb) return 4'b0000;
    return one << ba;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    logic       rcs;
    bank_addr_t rba;
    checks   = 0;
    failures = 0;
    ResetN   = 1'b0;
    ifc.CS = 1'b1; ifc.BSIn = '0;
    ifr.CS = 1'b1; ifr.BSIn = '0;
    if3.CS = 1'b1; if3.BSIn = '0;

    // reset state
    #3;
    chk("rst_comb", ifc.BSOut, 4'b0000);
    chk("rst_reg",  ifr.BSOut, 4'b0000);
    chk("rst_nb3",  {1'b0, if3.BSOut}, 4'b0000);

    // comb sweep, chip selected
    #2;
    ResetN = 1'b1;
    ifc.CS = 1'b0;
    ifc.BSIn = 2'd0; #10; chk("sel_b0", ifc.BSOut, 4'b0001);
    ifc.BSIn = 2'd1; #10; chk("sel_b1", ifc.BSOut, 4'b0010);
    ifc.BSIn = 2'd2; #10; chk("sel_b2", ifc.BSOut, 4'b0100);
    ifc.BSIn = 2'd3; #10; chk("sel_b3", ifc.BSOut, 4'b1000);

    // comb sweep, chip deselected
    ifc.CS = 1'b1;
    ifc.BSIn = 2'd0; #10; chk("desel_b0", ifc.BSOut, 4'b0000);
    ifc.BSIn = 2'd1; #10; chk("desel_b1", ifc.BSOut, 4'b0000);
    ifc.BSIn = 2'd2; #10; chk("desel_b2", ifc.BSOut, 4'b0000);
    ifc.BSIn = 2'd3; #10; chk("desel_b3", ifc.BSOut, 4'b0000);

    // async reset on the comb path, then release
    ifc.CS = 1'b0; ifc.BSIn = 2'd2;
    ResetN = 1'b0; #10; chk("comb_in_rst", ifc.BSOut, 4'b0000);
    ResetN = 1'b1; #1;  chk("comb_rst_rel", ifc.BSOut, 4'b0100);

    // registered path: one-cycle latency
    @(negedge Clk); ifr.CS = 1'b1; ifr.BSIn = 2'd0;
    @(posedge Clk); #1; chk("reg_desel", ifr.BSOut, 4'b0000);
    @(negedge Clk); ifr.CS = 1'b0; ifr.BSIn = 2'd1;
    #1; chk("reg_hold0", ifr.BSOut, 4'b0000);
    @(posedge Clk); #1; chk("reg_b1", ifr.BSOut, 4'b0010);
    @(negedge Clk); #3; ifr.BSIn = 2'd3;
    #1; chk("reg_hold1", ifr.BSOut, 4'b0010);
    @(posedge Clk); #1; chk("reg_b3", ifr.BSOut, 4'b1000);
    #4; ResetN = 1'b0;
    #1; chk("reg_async_rst", ifr.BSOut, 4'b0000);
    @(posedge Clk); #1; chk("reg_in_rst", ifr.BSOut, 4'b0000);
    @(negedge Clk); ResetN = 1'b1;
    #1; chk("reg_rel_hold", ifr.BSOut, 4'b0000);
    @(posedge Clk); #1; chk("reg_first_load", ifr.BSOut, 4'b1000);

    // three banks: out-of-range and unknown inputs
    if3.CS = 1'b0;
    if3.BSIn = 2'd3; #10; chk("nb3_oor", {1'b0, if3.BSOut}, 4'b0000);
    if3.BSIn = 2'd2; #10; chk("nb3_b2",  {1'b0, if3.BSOut}, 4'b0100);
    if3.BSIn = 2'd0; #10; chk("nb3_b0",  {1'b0, if3.BSOut}, 4'b0001);
    if3.BSIn = 2'bxx; #10;
    chk("nb3_ba_x", {1'b0, if3.BSOut}, ref_dec(if3.CS, if3.BSIn, 3));
    if3.BSIn = 2'd1; if3.CS = 1'bx; #10;
    chk("nb3_cs_x", {1'b0, if3.BSOut}, ref_dec(if3.CS, if3.BSIn, 3));

    // random traffic on all three instances
    for (int n = 0; n < 1000; n++) begin
      @(negedge Clk);
      rcs = 1'($urandom_range(0, 1));
      rba = 2'($urandom_range(0, 3));
      ifc.CS = rcs; ifc.BSIn = rba;
      ifr.CS = rcs; ifr.BSIn = rba;
      if3.CS = 1'($urandom_range(0, 1));
      if3.BSIn = 2'($urandom_range(0, 3));
      #1;
      chk("rnd_comb", ifc.BSOut, ref_dec(rcs, rba, 4));
      chk("rnd_nb3", {1'b0, if3.BSOut}, ref_dec(if3.CS, if3.BSIn, 3));
      @(posedge Clk); #1;
      chk("rnd_reg", ifr.BSOut, ref_dec(rcs, rba, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
